// File: rtl/ccc_refclk_sync_ctrl.sv
// ccc_refclk_sync_ctrl: drives REFCLK_SYNC_EN through assert/hold/release and waits for stable PLL lock
module ccc_refclk_sync_ctrl #(
  parameter logic [1:0] PLL_MASK = 2'b11,
  parameter int SYNC_HOLD_CYCLES = 16,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       PLL0_REFCLK_SYNC_EN,
  input  logic       PLL1_REFCLK_SYNC_EN,
  input  logic       PLL0_LOCK,
  input  logic       PLL1_LOCK,
  output logic       REFCLK_SYNC_EN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [1:0] ERR_CODE
);
  localparam logic [2:0] IDLE = 3'd0, ASSERT = 3'd1, HOLD = 3'd2, RELEASE = 3'd3,
                         LOCKW = 3'd4, DONE_ST = 3'd5, ERR_ST = 3'd6;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SYNC_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [1:0] ech_s1, ech_s2, lck_s1, lck_s2;
  logic [2:0] state, state_n;
  logic [CNT_W-1:0] cnt, stab;
  logic ech_all, ech_none, lck_all, entering;
  logic [1:0] code_n;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      ech_s1 <= '0;
      ech_s2 <= '0;
      lck_s1 <= '0;
      lck_s2 <= '0;
    end else begin
      ech_s1 <= {PLL1_REFCLK_SYNC_EN, PLL0_REFCLK_SYNC_EN};
      ech_s2 <= ech_s1;
      lck_s1 <= {PLL1_LOCK, PLL0_LOCK};
      lck_s2 <= lck_s1;
    end
  // masked PLLs read as echo-ok and locked, so an empty mask passes every check
  assign ech_all  = &(ech_s2 | ~PLL_MASK);
  assign ech_none = ~|(ech_s2 & PLL_MASK);
  assign lck_all  = &(lck_s2 | ~PLL_MASK);
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE_ST, ERR_ST: state_n = START ? ASSERT : state;
      ASSERT:  state_n = ech_all ? HOLD : (cnt == TO_LAST) ? ERR_ST : ASSERT;
      HOLD:    state_n = (cnt == HOLD_LAST) ? RELEASE : HOLD;
      RELEASE: state_n = ech_none ? LOCKW : (cnt == TO_LAST) ? ERR_ST : RELEASE;
      LOCKW:   state_n = (lck_all && stab == STAB_LAST) ? DONE_ST : (cnt == TO_LAST) ? ERR_ST : LOCKW;
      default: state_n = IDLE;
    endcase
  end
  assign entering = state_n != state;
  assign code_n = (state == ASSERT) ? 2'b01 : (state == RELEASE) ? 2'b10 : 2'b11;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      stab <= '0;
      REFCLK_SYNC_EN <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ERROR <= 1'b0;
      ERR_CODE <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= entering ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      stab <= (entering || !lck_all) ? '0 : (stab == CNT_MAX) ? stab : stab + 1'b1;
      REFCLK_SYNC_EN <= state_n inside {ASSERT, HOLD};
      BUSY <= state_n inside {ASSERT, HOLD, RELEASE, LOCKW};
      if (entering && state_n == ASSERT) begin
        DONE <= 1'b0;
        ERROR <= 1'b0;
        ERR_CODE <= 2'b00;
      end
      if (entering && state_n == DONE_ST) DONE <= 1'b1;
      if (entering && state_n == ERR_ST) begin
        ERROR <= 1'b1;
        ERR_CODE <= code_n;
      end
    end
endmodule

// File: tb/tb_ccc_refclk_sync_ctrl.sv
// tb_ccc_refclk_sync_ctrl: directed vectors over nominal, timeout, glitch, spam and reset scenarios
module tb_ccc_refclk_sync_ctrl;
  logic CLK = 1'b0, RESET = 1'b0;
  logic st_a, l0_a, l1_a, en_a, busy_a, done_a, err_a;
  logic st_b, l0_b, l1_b, en_b, busy_b, done_b, err_b, b_hi, b_lo;
  logic st_c, l0_c, l1_c, en_c, busy_c, done_c, err_c;
  logic [1:0] code_a, code_b, code_c, da = '0, db = '0, dc = '0;
  logic e0_a, e1_a, e0_b, e1_b, e0_c, e1_c;
  int vectors = 0, fails = 0;
  int t_done, en_hi;
  always #5 CLK = ~CLK;
  // clock-root echo model: follows REFCLK_SYNC_EN two cycles late
  always @(posedge CLK) begin
    da <= {da[0], en_a};
    db <= {db[0], en_b};
    dc <= {dc[0], en_c};
  end
  assign e0_a = da[1];
  assign e1_a = da[1];
  assign e0_b = db[1];
  assign e1_b = b_hi ? 1'b1 : b_lo ? 1'b0 : db[1];
  assign e0_c = dc[1];
  assign e1_c = 1'b0;
  ccc_refclk_sync_ctrl u_a (
    .CLK(CLK), .RESET(RESET), .START(st_a), .PLL0_REFCLK_SYNC_EN(e0_a), .PLL1_REFCLK_SYNC_EN(e1_a),
    .PLL0_LOCK(l0_a), .PLL1_LOCK(l1_a), .REFCLK_SYNC_EN(en_a), .BUSY(busy_a), .DONE(done_a),
    .ERROR(err_a), .ERR_CODE(code_a));
  ccc_refclk_sync_ctrl #(.TIMEOUT_CYCLES(32)) u_b (
    .CLK(CLK), .RESET(RESET), .START(st_b), .PLL0_REFCLK_SYNC_EN(e0_b), .PLL1_REFCLK_SYNC_EN(e1_b),
    .PLL0_LOCK(l0_b), .PLL1_LOCK(l1_b), .REFCLK_SYNC_EN(en_b), .BUSY(busy_b), .DONE(done_b),
    .ERROR(err_b), .ERR_CODE(code_b));
  ccc_refclk_sync_ctrl #(.PLL_MASK(2'b01)) u_c (
    .CLK(CLK), .RESET(RESET), .START(st_c), .PLL0_REFCLK_SYNC_EN(e0_c), .PLL1_REFCLK_SYNC_EN(e1_c),
    .PLL0_LOCK(l0_c), .PLL1_LOCK(l1_c), .REFCLK_SYNC_EN(en_c), .BUSY(busy_c), .DONE(done_c),
    .ERROR(err_c), .ERR_CODE(code_c));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // one START pulse on u_a; returns the cycle DONE/ERROR appears and the REFCLK_SYNC_EN high count
  task automatic run_a(input int glitch_at, output int td, output int hi);
    td = 0;
    hi = 0;
    st_a = 1'b1;
    for (int n = 1; n <= 400 && td == 0; n++) begin
      @(negedge CLK);
      st_a = 1'b0;
      if (en_a) hi++;
      if (n == glitch_at) l0_a = 1'b0;
      else if (n == glitch_at + 1) l0_a = 1'b1;
      if (done_a || err_a) td = n;
    end
  endtask
  initial begin
    {st_a, st_b, st_c, b_hi, b_lo} = '0;
    {l0_a, l1_a, l0_b, l1_b} = 4'hf;
    {l0_c, l1_c} = 2'b00;
    #1 RESET = 1'b1;
    #2;
    chk("rst_en", en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_flags", {done_a, err_a, code_a}, 0);
    chk("rst_b", {en_b, busy_b, done_b, err_b, code_b}, 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    run_a(0, t_done, en_hi);
    chk("nom_done_t", t_done, 91);
    chk("nom_en_hi", en_hi, 21);
    chk("nom_done", done_a, 1);
    chk("nom_err", {err_a, code_a}, 0);
    chk("nom_busy", busy_a, 0);
    repeat (3) @(negedge CLK);
    run_a(67, t_done, en_hi);
    chk("glitch_done_t", t_done, 134);
    chk("glitch_flags", {done_a, err_a, code_a}, 4'b1000);
    repeat (3) @(negedge CLK);
    st_a = 1'b1;
    repeat (90) @(negedge CLK);
    chk("spam_early", {done_a, busy_a}, 2'b01);
    @(negedge CLK);
    chk("spam_done", {done_a, busy_a}, 2'b10);
    @(negedge CLK);
    chk("spam_restart", {done_a, busy_a, en_a}, 3'b011);
    repeat (8) @(negedge CLK);
    st_a = 1'b0;
    repeat (81) @(negedge CLK);
    chk("spam2_early", done_a, 0);
    @(negedge CLK);
    chk("spam2_done", {done_a, err_a}, 2'b10);
    b_lo = 1'b1;
    st_b = 1'b1;
    @(negedge CLK);
    st_b = 1'b0;
    chk("b_start_lat", {en_b, busy_b}, 2'b11);
    repeat (31) @(negedge CLK);
    chk("ato_before", {err_b, en_b}, 2'b01);
    @(negedge CLK);
    chk("ato_err", {err_b, code_b}, 3'b101);
    chk("ato_idle", {en_b, busy_b, done_b}, 0);
    b_lo = 1'b0;
    b_hi = 1'b1;
    repeat (3) @(negedge CLK);
    st_b = 1'b1;
    @(negedge CLK);
    st_b = 1'b0;
    chk("b_clear", {err_b, code_b}, 0);
    repeat (52) @(negedge CLK);
    chk("rto_before", {err_b, busy_b}, 2'b01);
    @(negedge CLK);
    chk("rto_err", {err_b, code_b, busy_b}, 4'b1100);
    st_c = 1'b1;
    @(negedge CLK);
    st_c = 1'b0;
    repeat (4121) @(negedge CLK);
    chk("lto_before", {err_c, busy_c}, 2'b01);
    @(negedge CLK);
    chk("lto_err", {err_c, code_c, busy_c}, 4'b1110);
    l0_c = 1'b1;
    repeat (3) @(negedge CLK);
    st_c = 1'b1;
    @(negedge CLK);
    st_c = 1'b0;
    chk("c_clear", {err_c, code_c}, 0);
    repeat (89) @(negedge CLK);
    chk("c_early", done_c, 0);
    @(negedge CLK);
    chk("c_done", {done_c, err_c, code_c}, 4'b1000);
    st_a = 1'b1;
    @(negedge CLK);
    st_a = 1'b0;
    repeat (10) @(negedge CLK);
    chk("hold_en", {en_a, busy_a}, 2'b11);
    #2 RESET = 1'b1;
    #1;
    chk("arst_en", {en_a, busy_a}, 0);
    chk("arst_flags", {err_b, code_b, done_c}, 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    run_a(0, t_done, en_hi);
    chk("post_rst_t", t_done, 91);
    chk("post_rst_flags", {done_a, err_a, code_a}, 4'b1000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
